rom_access_arbiter: RTL and testbench

ROM_ACCESS_ARBITER -- requirements
Module: rom_access_arbiter

---
 rtl/rom_access_arbiter_if.sv | 30 +++
 rtl/rom_access_arbiter.sv | 110 +++++++++++
 tb/tb_rom_access_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_access_arbiter_if.sv
// Bundles the display, aux and ROM signals of the ROM access arbiter.
// The slave modport belongs to the arbiter. The master modport belongs to the requesters and ROM.
interface rom_access_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) ();
  logic              dispReq;
  logic [ADDR_W-1:0] dispAddr;
  logic              dispValid;
  logic [DATA_W-1:0] dispData;
  logic              dispOverrun;
  logic              auxReq;
  logic [ADDR_W-1:0] auxAddr;
  logic              auxGrant;
  logic              auxValid;
  logic [DATA_W-1:0] auxData;
  logic              romEn;
  logic [ADDR_W-1:0] romAddr;
  logic [DATA_W-1:0] romData;

  modport slave (
    input  dispReq, dispAddr, auxReq, auxAddr, romData,
    output dispValid, dispData, dispOverrun, auxGrant, auxValid, auxData, romEn, romAddr
  );

  modport master (
    output dispReq, dispAddr, auxReq, auxAddr, romData,
    input  dispValid, dispData, dispOverrun, auxGrant, auxValid, auxData, romEn, romAddr
  );
endinterface

// File: rtl/rom_access_arbiter.sv
// Shares one character ROM between the display fetcher and an aux requester.
// Display has priority, and a starvation counter forces an occasional aux slot.
module rom_access_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 15
) (
  input  logic                 pixelClk,
  input  logic                 reset,
  rom_access_arbiter_if.slave  bus
);
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_AUX} tag_e;

  logic              hold_v_q, hold_v_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              overrun_q, overrun_d;
  tag_e              win_tag_d;
  logic [ADDR_W-1:0] win_addr_d;
  logic              forced;

  logic              rom_en_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              aux_grant_q;
  tag_e              tag0_q, tag1_q;
  logic              disp_valid_q, aux_valid_q;
  logic [DATA_W-1:0] disp_data_q, aux_data_q;

  assign forced = bus.auxReq && (starve_q == STARVE_LIM);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    win_tag_d   = TAG_NONE;
    win_addr_d  = rom_addr_q;
    hold_v_d    = hold_v_q;
    hold_addr_d = hold_addr_q;
    overrun_d   = overrun_q;
    starve_d    = starve_q;

    if (hold_v_q) begin
      // The held request drains this cycle. A display pulse arriving now has nowhere to go.
      win_tag_d  = TAG_DISP;
      win_addr_d = hold_addr_q;
      hold_v_d   = 1'b0;
      if (bus.dispReq) overrun_d = 1'b1;
    end else if (forced) begin
      win_tag_d  = TAG_AUX;
      win_addr_d = bus.auxAddr;
      if (bus.dispReq) begin
        hold_v_d    = 1'b1;
        hold_addr_d = bus.dispAddr;
      end
    end else if (bus.dispReq) begin
      win_tag_d  = TAG_DISP;
      win_addr_d = bus.dispAddr;
    end else if (bus.auxReq) begin
      win_tag_d  = TAG_AUX;
      win_addr_d = bus.auxAddr;
    end

    if (!bus.auxReq || win_tag_d == TAG_AUX) starve_d = '0;
    else if (starve_q != STARVE_LIM)         starve_d = starve_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      hold_v_q     <= 1'b0;
      hold_addr_q  <= '0;
      starve_q     <= '0;
      overrun_q    <= 1'b0;
      rom_en_q     <= 1'b0;
      rom_addr_q   <= '0;
      aux_grant_q  <= 1'b0;
      tag0_q       <= TAG_NONE;
      tag1_q       <= TAG_NONE;
      disp_valid_q <= 1'b0;
      aux_valid_q  <= 1'b0;
      disp_data_q  <= '0;
      aux_data_q   <= '0;
    end else begin
      hold_v_q     <= hold_v_d;
      hold_addr_q  <= hold_addr_d;
      starve_q     <= starve_d;
      overrun_q    <= overrun_d;
      rom_en_q     <= (win_tag_d != TAG_NONE);
      rom_addr_q   <= win_addr_d;
      aux_grant_q  <= (win_tag_d == TAG_AUX);
      // The tag follows its read: issue, ROM access, then data capture.
      tag0_q       <= win_tag_d;
      tag1_q       <= tag0_q;
      disp_valid_q <= (tag1_q == TAG_DISP);
      aux_valid_q  <= (tag1_q == TAG_AUX);
      if (tag1_q == TAG_DISP) disp_data_q <= bus.romData;
      if (tag1_q == TAG_AUX)  aux_data_q  <= bus.romData;
    end
  end

  assign bus.romEn       = rom_en_q;
  assign bus.romAddr     = rom_addr_q;
  assign bus.auxGrant    = aux_grant_q;
  assign bus.dispValid   = disp_valid_q;
  assign bus.dispData    = disp_data_q;
  assign bus.auxValid    = aux_valid_q;
  assign bus.auxData     = aux_data_q;
  assign bus.dispOverrun = overrun_q;
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter. It compares every cycle against a schedule-based reference model.
// Each arbitration decision posts its future outputs into per-cycle expectation tables.
module tb_rom_access_arbiter;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int SMAX = 15;
  localparam int NC = 4096;

  logic pixelClk = 1'b0;
  logic reset = 1'b1;

  rom_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  rom_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .pixelClk (pixelClk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 pixelClk = ~pixelClk;

  // ROM model: the data appears in the cycle after romEn.
  logic [DW-1:0] mem [128];
  always @(posedge pixelClk) if (bus.romEn) bus.romData <= mem[bus.romAddr];

  // Expectation tables, indexed by cycle number.
  bit          e_en [NC];
  logic [AW-1:0] e_addr [NC];
  bit          e_grant [NC];
  bit          e_dv [NC];
  bit          e_av [NC];
  logic [DW-1:0] e_d [NC];
  bit          e_ovr [NC];
  bit          e_rst [NC];

  // Reference state: one-slot display backlog and aux wait count.
  bit            m_hold_v;
  logic [AW-1:0] m_hold_a;
  int            m_wait;

  // Expected output registers for the current cycle.
  logic          x_en, x_grant, x_dv, x_av, x_ovr;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_dd, x_ad;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  function automatic logic [27:0] obs();
    return {bus.romEn, bus.romAddr, bus.auxGrant, bus.dispValid, bus.dispData,
            bus.auxValid, bus.auxData, bus.dispOverrun};
  endfunction

  function automatic logic [27:0] expv();
    return {x_en, x_addr, x_grant, x_dv, x_dd, x_av, x_ad, x_ovr};
  endfunction

  task automatic model(input bit d, input logic [AW-1:0] da, input bit a,
                       input logic [AW-1:0] aa, input bit r);
    int c;
    int w;              // 0 none, 1 display, 2 aux
    logic [AW-1:0] wa;
    c = cyc;
    if (r) begin
      for (int k = 1; k <= 3; k++) begin
        e_en[c+k] = 0; e_grant[c+k] = 0; e_dv[c+k] = 0; e_av[c+k] = 0; e_ovr[c+k] = 0;
      end
      e_rst[c+1] = 1;
      m_hold_v = 0;
      m_wait = 0;
      return;
    end
    w = 0;
    wa = '0;
    if (m_hold_v) begin
      w = 1; wa = m_hold_a; m_hold_v = 0;
      if (d) e_ovr[c+1] = 1;
    end else if (a && m_wait == SMAX) begin
      w = 2; wa = aa;
      if (d) begin m_hold_v = 1; m_hold_a = da; end
    end else if (d) begin
      w = 1; wa = da;
    end else if (a) begin
      w = 2; wa = aa;
    end
    if (!a || w == 2) m_wait = 0;
    else if (m_wait < SMAX) m_wait = m_wait + 1;
    if (w != 0) begin
      e_en[c+1] = 1;
      e_addr[c+1] = wa;
      e_grant[c+1] = (w == 2);
      e_dv[c+3] = (w == 1);
      e_av[c+3] = (w == 2);
      e_d[c+3] = mem[wa];
    end
  endtask

  // Drive one cycle of inputs, step the model, and move to the next cycle's expectations.
  task automatic step(input bit d, input logic [AW-1:0] da, input bit a,
                      input logic [AW-1:0] aa, input bit r);
    @(negedge pixelClk);
    bus.dispReq = d; bus.dispAddr = da; bus.auxReq = a; bus.auxAddr = aa; reset = r;
    model(d, da, a, aa, r);
    @(posedge pixelClk);
    #1;
    cyc++;
    if (e_rst[cyc]) begin x_addr = '0; x_dd = '0; x_ad = '0; x_ovr = 0; end
    x_en = e_en[cyc];
    x_grant = e_grant[cyc];
    x_dv = e_dv[cyc];
    x_av = e_av[cyc];
    if (x_en) x_addr = e_addr[cyc];
    if (x_dv) x_dd = e_d[cyc];
    if (x_av) x_ad = e_d[cyc];
    if (e_ovr[cyc]) x_ovr = 1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, '0, 0, '0, i < 2);
      n_total++;
      if (obs() !== expv()) $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (dut.starve_q !== 4'd0) $display("FAIL reset_counter got=%0d want=0", dut.starve_q);
    else n_pass++;
  endtask

  task automatic test_disp_single();
    for (int i = 0; i < 5; i++) begin
      step(i == 0, 7'h23, 0, '0, 0);
      n_total++;
      if (obs() !== expv()) $display("FAIL disp_single cyc=%0d got=%h want=%h", cyc, obs(), expv());
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if (bus.romEn !== 1'b1 || bus.romAddr !== 7'h23)
          $display("FAIL disp_issue got=%b/%h want=1/23", bus.romEn, bus.romAddr);
        else n_pass++;
      end
      if (i == 2) begin
        n_total++;
        if (bus.dispValid !== 1'b1 || bus.dispData !== 8'hA5)
          $display("FAIL disp_data got=%b/%h want=1/a5", bus.dispValid, bus.dispData);
        else n_pass++;
      end
    end
  endtask

  task automatic test_aux_single();
    for (int i = 0; i < 5; i++) begin
      step(0, '0, i == 0, 7'h10, 0);
      n_total++;
      if (obs() !== expv()) $display("FAIL aux_single cyc=%0d got=%h want=%h", cyc, obs(), expv());
      else n_pass++;
      if (i == 0) begin
        n_total++;
        if (bus.auxGrant !== 1'b1) $display("FAIL aux_grant got=%b want=1", bus.auxGrant);
        else n_pass++;
      end
      if (i == 2) begin
        n_total++;
        if (bus.auxValid !== 1'b1 || bus.auxData !== 8'h3C || dut.starve_q !== 4'd0)
          $display("FAIL aux_data got=%b/%h cnt=%0d want=1/3c cnt=0", bus.auxValid, bus.auxData, dut.starve_q);
        else n_pass++;
      end
    end
  endtask

  // Back-to-back display starves aux until the forced slot. An extra pulse can then hit the full hold.
  task automatic test_starve(input bit overrun);
    for (int i = 0; i < 22; i++) begin
      step(i < 16 || (overrun && i == 16), 7'(8'h40 + i), i < 16, 7'h11, 0);
      n_total++;
      if (obs() !== expv()) $display("FAIL starve cyc=%0d got=%h want=%h", cyc, obs(), expv());
      else n_pass++;
      if (i == 15) begin
        n_total++;
        if (bus.auxGrant !== 1'b1) $display("FAIL forced_grant got=%b want=1", bus.auxGrant);
        else n_pass++;
      end
      if (i == 16) begin
        n_total++;
        if (bus.romAddr !== 7'h4F || bus.dispOverrun !== overrun)
          $display("FAIL held_issue got=%h ovr=%b want=4f ovr=%b", bus.romAddr, bus.dispOverrun, overrun);
        else n_pass++;
      end
      if (i == 18) begin
        n_total++;
        if (bus.dispValid !== 1'b1 || bus.dispData !== mem[7'h4F])
          $display("FAIL held_latency got=%b/%h want=1/%h", bus.dispValid, bus.dispData, mem[7'h4F]);
        else n_pass++;
      end
    end
    n_total++;
    if (bus.dispOverrun !== overrun) $display("FAIL overrun_sticky got=%b want=%b", bus.dispOverrun, overrun);
    else n_pass++;
    if (overrun) begin
      step(0, '0, 0, '0, 1);
      n_total++;
      if (obs() !== expv() || bus.dispOverrun !== 1'b0)
        $display("FAIL overrun_clear got=%h want=%h", obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_withdraw();
    for (int i = 0; i < 8; i++) begin
      step(i < 5, 7'(8'h50 + i), i < 5, 7'h12, 0);
      n_total++;
      if (obs() !== expv() || bus.auxGrant !== 1'b0)
        $display("FAIL withdraw cyc=%0d got=%h want=%h", cyc, obs(), expv());
      else n_pass++;
    end
    n_total++;
    if (dut.starve_q !== 4'd0) $display("FAIL withdraw_counter got=%0d want=0", dut.starve_q);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      step(i == 0, 7'h23, 0, '0, i == 2);
      n_total++;
      if (obs() !== expv() || (i >= 2 && bus.dispValid !== 1'b0))
        $display("FAIL reset_mid cyc=%0d got=%h want=%h", cyc, obs(), expv());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit a_on;
    logic [AW-1:0] a_addr;
    bit d, r;
    a_on = 0;
    a_addr = '0;
    for (int i = 0; i < 400; i++) begin
      if (!a_on && $urandom_range(0, 3) == 0) begin a_on = 1; a_addr = 7'($urandom); end
      else if (a_on && $urandom_range(0, 19) == 0) a_on = 0;
      d = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(d, 7'($urandom), a_on, a_addr, r);
      if (r) a_on = 0;
      if (x_grant && $urandom_range(0, 3) != 0) a_on = 0;
      n_total++;
      if (obs() !== expv()) $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs(), expv());
      else n_pass++;
    end
  endtask

  initial begin
    bus.dispReq = 0; bus.dispAddr = '0; bus.auxReq = 0; bus.auxAddr = '0;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[7'h23] = 8'hA5;
    mem[7'h10] = 8'h3C;
    m_hold_v = 0; m_hold_a = '0; m_wait = 0;
    x_en = 0; x_grant = 0; x_dv = 0; x_av = 0; x_ovr = 0;
    x_addr = '0; x_dd = '0; x_ad = '0;
    test_reset();
    test_disp_single();
    test_aux_single();
    test_starve(0);
    test_withdraw();
    test_starve(1);
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
